// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier. Consumes the flag from an external
// iteration counter to end the loop, with a watchdog in case that flag never arrives.
module shift_add_mult_ctrl #(
    parameter int DW       = 16,
    parameter int WD_LIMIT = DW + 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    input  logic            cnt_flag,
    output logic            cnt_enable,
    output logic            cnt_sync_reset,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product,
    output logic            err
);

    localparam int WDW = $clog2(WD_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [DW-1:0]     m_r;
    logic [DW-1:0]     q_r;
    logic [DW:0]       a_r;
    logic [WDW-1:0]    wd_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [2*DW-1:0]   product_r;

    logic [DW:0]       sum_s;
    logic [DW:0]       a_next_s;
    logic [DW-1:0]     q_next_s;

    // One iteration: conditional add into A (carry kept), then shift {A,Q} right by one.
    always_comb begin
        sum_s    = a_r + (q_r[0] ? {1'b0, m_r} : {(DW+1){1'b0}});
        a_next_s = {1'b0, sum_s[DW:1]};
        q_next_s = {sum_s[0], q_r[DW-1:1]};
    end

    // Counter control and ready decode from the current state, qualified by start in IDLE.
    always_comb begin
        cnt_enable     = 1'b0;
        cnt_sync_reset = 1'b0;
        ready          = 1'b0;
        case (state_r)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    cnt_enable     = 1'b1;
                    cnt_sync_reset = 1'b1;
                end else begin
                    cnt_enable     = 1'b0;
                    cnt_sync_reset = 1'b0;
                end
            end
            RUN: begin
                cnt_enable = 1'b1;
            end
            default: begin
                cnt_enable     = 1'b0;
                cnt_sync_reset = 1'b0;
                ready          = 1'b0;
            end
        endcase
    end

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            m_r       <= {DW{1'b0}};
            q_r       <= {DW{1'b0}};
            a_r       <= {(DW+1){1'b0}};
            wd_r      <= {WDW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            product_r <= {(2*DW){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        m_r     <= multiplicand;
                        q_r     <= multiplier;
                        a_r     <= {(DW+1){1'b0}};
                        wd_r    <= {WDW{1'b0}};
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_r <= a_next_s;
                    q_r <= q_next_s;
                    if (cnt_flag) begin
                        product_r <= {a_next_s[DW-1:0], q_next_s};
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else if (wd_r == WDW'(WD_LIMIT - 1)) begin
                        // Counter never reported the last iteration: abort with a zero result.
                        err_r     <= 1'b1;
                        product_r <= {(2*DW){1'b0}};
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        wd_r <= wd_r + WDW'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign product = product_r;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench: models the iteration counter and a cycle-timeline reference
// of the multiplier, comparing every cycle, plus literal checks of key results.
module tb_shift_add_mult_ctrl;

    localparam int DW       = 16;
    localparam int WD_LIMIT = DW + 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic            cnt_flag;
    logic            cnt_enable;
    logic            cnt_sync_reset;
    logic            ready;
    logic            busy;
    logic            done;
    logic [2*DW-1:0] product;
    logic            err;

    shift_add_mult_ctrl #(.DW(DW), .WD_LIMIT(WD_LIMIT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .cnt_flag(cnt_flag), .cnt_enable(cnt_enable), .cnt_sync_reset(cnt_sync_reset),
        .ready(ready), .busy(busy), .done(done), .product(product), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Iteration counter model: counts while enabled, flag at DW-1; can be disconnected or forced.
    logic [7:0] cnt;
    bit connected  = 1'b1;
    bit force_flag = 1'b0;
    always @(posedge clk) begin
        if (reset)           cnt <= 8'd0;
        else if (cnt_enable) cnt <= cnt_sync_reset ? 8'd0 : cnt + 8'd1;
    end
    assign cnt_flag = (connected && cnt == 8'(DW - 1)) || force_flag;

    // Reference timeline: t = 0 idle, 1..run_len iterating, run_len+1 result cycle.
    int          t        = 0;
    int          run_len  = DW;
    bit          model_ok = 1'b0;
    bit          wd_case  = 1'b0;
    logic [31:0] ma, mb;
    logic [31:0] exp_product = 32'd0;
    logic        exp_err     = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            t = 0; exp_product = 32'd0; exp_err = 1'b0; model_ok = 1'b1;
        end else if (model_ok) begin
            if (t == 0) begin
                if (start) begin
                    ma = {16'd0, multiplicand};
                    mb = {16'd0, multiplier};
                    exp_err = 1'b0;
                    wd_case = !connected;
                    run_len = connected ? DW : WD_LIMIT;
                    t = 1;
                end
            end else if (t < run_len) begin
                t = t + 1;
            end else if (t == run_len) begin
                exp_product = wd_case ? 32'd0 : ma * mb;
                exp_err     = wd_case;
                t = t + 1;
            end else begin
                t = 0;
            end
        end
    end

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        if (model_ok && !reset) begin
            check("ready", 64'(ready), 64'(t == 0));
            check("busy", 64'(busy), 64'(t >= 1 && t <= run_len));
            check("done", 64'(done), 64'(t == run_len + 1));
            check("err", 64'(err), 64'(exp_err));
            check("cnt_enable", 64'(cnt_enable), 64'((t == 0 && start) || (t >= 1 && t <= run_len)));
            check("cnt_sync_reset", 64'(cnt_sync_reset), 64'(t == 0 && start));
            if (t == 0 || t == run_len + 1)
                check("product", 64'(product), 64'(exp_product));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (t != 0 && k < 100) begin step(); k++; end
        if (t != 0) check("wait_idle_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit hold,
                          input logic [31:0] lit_prod, input int lit_lat, input logic lit_err);
        int cyc;
        wait_idle();
        start = 1'b1; multiplicand = a; multiplier = b;
        step();
        if (hold) begin
            multiplicand = ~a; multiplier = ~b;
        end else begin
            start = 1'b0;
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin step(); cyc++; end
        check("done_latency", 64'(cyc), 64'(lit_lat));
        check("lit_product", 64'(product), 64'(lit_prod));
        check("lit_err", 64'(err), 64'(lit_err));
        if (hold) begin
            step();
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        reset = 1'b1; start = 1'b0; multiplicand = 16'd0; multiplier = 16'd0;
        step(); step();
        reset = 1'b0;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_product", 64'(product), 64'(0));
        check("rst_cnt_enable", 64'(cnt_enable), 64'(0));

        run_op(16'd3, 16'd5, 1'b0, 32'h0000000F, 17, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17, 1'b0);
        run_op(16'h1234, 16'h0000, 1'b0, 32'h0, 17, 1'b0);
        run_op(16'h0000, 16'hABCD, 1'b0, 32'h0, 17, 1'b0);
        run_op(16'h00FF, 16'h0101, 1'b1, 32'h0000FFFF, 17, 1'b0);
        wait_idle();

        // Abort at the eighth iteration with reset.
        start = 1'b1; multiplicand = 16'd7; multiplier = 16'd9;
        step();
        start = 1'b0;
        while (t != 8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_product", 64'(product), 64'(0));
        check("abort_ready", 64'(ready), 64'(1));
        check("abort_done", 64'(done), 64'(0));
        run_op(16'd7, 16'd9, 1'b0, 32'd63, 17, 1'b0);

        // Disconnected counter: watchdog ends the run.
        connected = 1'b0;
        run_op(16'd5, 16'd6, 1'b0, 32'd0, WD_LIMIT + 1, 1'b1);
        wait_idle();
        connected = 1'b1;
        run_op(16'd5, 16'd6, 1'b0, 32'd30, 17, 1'b0);

        // Random operands, random start holding, spurious flags while idle.
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 5 == 0) ra = 16'hFFFF;
            run_op(ra, rb, 1'($urandom_range(0, 3) == 0), {16'd0, ra} * {16'd0, rb}, 17, 1'b0);
            wait_idle();
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                force_flag = 1'($urandom_range(0, 1));
                step();
            end
            force_flag = 1'b0;
        end
        wait_idle();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Sequential unsigned shift-and-add multiplier. Its FSM is the consumer side of the iteration-counter interface. It drives enable and sync_reset into the standalone iteration counter and ends the iteration loop when that counter's flag reports DW-1. It presents a start/ready/done handshake to the practice top level and produces a 2*DW-bit product after DW iterations.

Parameters:
DW, Global::DW (16), operand width in bits; product is 2*DW bits.
WD_LIMIT, DW+2, RUN cycles without cnt_flag before the watchdog error fires.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
multiplicand  input  DW  operand A, sampled on accept
multiplier  input  DW  operand B, sampled on accept
cnt_flag  input  1  from iteration counter; 1 when its count equals DW-1
cnt_enable  output  1  to iteration counter enable
cnt_sync_reset  output  1  to iteration counter sync_reset (clears count when cnt_enable=1)
ready  output  1  FSM in IDLE, new start accepted
busy  output  1  FSM in RUN
done  output  1  one-cycle pulse, product valid
product  output  2*DW  result, held until next accept
err  output  1  sticky watchdog error, cleared on next accept or reset

Behaviour:
- Reset (reset=1 at a clk edge):
  - State goes to IDLE; acc, operand registers, product and err go to 0.
  - Outputs after reset: ready=1, busy=0, done=0, cnt_enable=0, cnt_sync_reset=0.
  - Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1, the accept cycle:
    - Latch multiplicand into M and multiplier into Q; clear A (DW+1 bits including carry).
    - Clear err and the watchdog count.
    - Drive cnt_enable=1 and cnt_sync_reset=1 combinationally so the counter reads 0 on the next cycle.
    - Go to RUN.
  - start=0: stay in IDLE; cnt_enable=0.
- RUN: one iteration per cycle, with cnt_enable=1 and cnt_sync_reset=0.
  - Iteration: if Q[0]=1, A = A + M (DW+1-bit sum, carry kept). Then {A,Q} shifts right 1 with 0 into the MSB.
  - cnt_flag=1 in a RUN cycle marks the last (DW-th) iteration. That iteration completes and the FSM goes to DONE; product <= {A,Q} after the final shift.
  - Watchdog: counts RUN cycles. If WD_LIMIT cycles pass without cnt_flag:
    - err is set to 1;
    - the FSM goes to DONE with product = 0;
    - cnt_enable drops.
  - start is ignored in RUN; ready=0, busy=1.
- DONE:
  - done=1 for exactly one cycle; cnt_enable=0; product valid; next state is IDLE.
  - start in DONE is ignored (ready=0).
- Latency: with the accept edge at cycle 0, RUN occupies cycles 1..DW, done=1 in cycle DW+1, and ready=1 again in cycle DW+2. Throughput is one product per DW+2 cycles.
- Arithmetic rules:
  - Unsigned, no overflow; the 2*DW result is exact.
  - The carry bit of A is required; without it the product is wrong for operands with MSB set.
- Outputs are registered, except cnt_enable, cnt_sync_reset and ready, which decode the current state (Moore), plus the start qualifier in IDLE.
- product is unchanged from DONE until the next accept edge; it is not cleared in IDLE.
- Boundary: cnt_flag=1 while in IDLE or DONE is ignored.

Test Plan:
- DW=16, A=3, B=5, start pulse:
  - cnt_enable=1 and cnt_sync_reset=1 in the accept cycle;
  - 16 RUN cycles;
  - done=1 in cycle 17 with product=0x0000000F, err=0.
- A=0xFFFF, B=0xFFFF: product=0xFFFE0001 (exercises the carry bit); done exactly 17 cycles after accept.
- A=0x1234, B=0: product=0. Back-to-back with A=0, B=0xABCD: product=0. done pulses each one cycle wide; the second start is accepted only when ready=1.
- Start held high during RUN with different operands: ignored, first product correct. Start still high in IDLE after DONE: new operation accepted.
- reset=1 at RUN cycle 8 of A=7, B=9: next cycle IDLE, product=0, no done pulse. Then A=7, B=9 completes with product=63.
- cnt_flag tied 0 (counter disconnected): err=1 and done=1 after WD_LIMIT=18 RUN cycles, product=0. The next normal operation clears err and gives the correct result.
